// File: rtl/mips_bus_stall_memory.sv
// Word-organised RAM slave for the mips_cpu_bus Avalon-style port.
// Inserts fixed or LFSR-driven waitrequest stalls ahead of each transaction
// and raises a sticky flag on initiator protocol violations.
module mips_bus_stall_memory #(
  parameter int          DEPTH_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
  parameter string       RAM_INIT_FILE = "",
  parameter int          STALL_CYCLES  = 2,
  parameter bit          RANDOM_STALL  = 1'b0,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        protocol_error
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic {IDLE, STALL} state_t;

  state_t      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic [7:0]  lfsr;
  logic [3:0]  n_cur;
  logic        req, accept, abort;
  logic [31:0] offset;
  logic        addr_ok;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];

  assign req     = read | write;
  assign n_cur   = RANDOM_STALL ? {2'b00, lfsr[1:0]} : STALL_CYCLES[3:0];
  assign offset  = address - BASE_ADDR;
  assign idx     = offset[AW+1:2];
  assign addr_ok = (address[1:0] == 2'b00) &&
                   ({2'b00, offset[31:2]} < 32'(DEPTH_WORDS));

  // Handshake FSM: count down N stalls, then accept; a dropped request aborts.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    waitrequest = 1'b0;
    accept      = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (n_cur == 4'd0) begin
            accept = 1'b1;
          end else begin
            waitrequest = 1'b1;
            count_nxt   = n_cur - 4'd1;
            state_nxt   = STALL;
          end
        end
      end
      STALL: begin
        if (!req) begin
          abort     = 1'b1;
          count_nxt = 4'd0;
          state_nxt = IDLE;
        end else if (count != 4'd0) begin
          waitrequest = 1'b1;
          count_nxt   = count - 4'd1;
        end else begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reset forces the bus quiet even while a request is still held.
    if (reset) waitrequest = 1'b0;
  end

  // Control state, LFSR, registered read data and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= 4'd0;
      lfsr           <= LFSR_SEED;
      readdata       <= 32'd0;
      protocol_error <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (accept) begin
        // Read wins over a simultaneous write; bad addresses read as zero.
        if (read) readdata <= addr_ok ? mem[idx] : 32'd0;
        if (!addr_ok || (read && write)) protocol_error <= 1'b1;
        if (RANDOM_STALL) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
      if (abort) protocol_error <= 1'b1;
    end
  end

  // Byte-lane RAM write; only a pure, in-range write changes contents.
  always_ff @(posedge clk) begin
    if (accept && write && !read && addr_ok) begin
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
    end
  end

endmodule
